// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU feeding the register-file write port: single-cycle logic ops, iterative MUL/DIV/MOD.
// Optional Zero/Overflow flags are built only when ULA_FLAGS_EN is defined; otherwise both read 0.
module ula_multiciclo #(
    parameter int LARGURA      = 8,
    parameter int NUM_REG_BITS = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Inicio,
    input  logic [2:0]              Op,
    input  logic [LARGURA-1:0]      Dado1,
    input  logic [LARGURA-1:0]      Dado2,
    input  logic [NUM_REG_BITS-1:0] RegDestino,
    output logic                    Ocupado,
    output logic                    Pronto,
    output logic [LARGURA-1:0]      DadoEscr,
    output logic [NUM_REG_BITS-1:0] RegEscr,
    output logic                    RegWrite,
    output logic                    Zero,
    output logic                    Overflow
);

    localparam int CW = $clog2(LARGURA);
    localparam logic [CW-1:0] ULTIMA = CW'(LARGURA - 1);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] ESCRITA = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b111;

    function automatic logic [LARGURA-1:0] operaSimples(input logic [2:0] op,
                                                       input logic [LARGURA-1:0] a,
                                                       input logic [LARGURA-1:0] b);
        logic signed [LARGURA-1:0] sa;
        logic signed [LARGURA-1:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return {{(LARGURA-1){1'b0}}, (sa < sb)};
            default: return '0;
        endcase
    endfunction

    function automatic logic ehMulticiclo(input logic [2:0] op);
        return op[2] && (op != OP_SLT);
    endfunction

    logic [1:0]              estado;
    logic [CW-1:0]           contador;
    logic [2:0]              opReg;
    logic [LARGURA-1:0]      aReg;
    logic [LARGURA-1:0]      bReg;
    logic [2*LARGURA-1:0]    produto;
    logic [LARGURA-1:0]      resto;
    logic [LARGURA-1:0]      quociente;

    logic [2*LARGURA-1:0]    produtoProx;
    logic [LARGURA:0]        restoDesl;
    logic [LARGURA-1:0]      restoProx;
    logic [LARGURA-1:0]      quocProx;
    logic [LARGURA-1:0]      resultadoSimples;
    logic [LARGURA-1:0]      resultadoProx;
    logic                    aceita;
    logic                    entraEscrita;

    // One shift-add / restoring-division step per CALC cycle; the dividend shifts out of quociente.
    always_comb begin
        produtoProx = produto + (bReg[contador] ? ({{LARGURA{1'b0}}, aReg} << contador) : '0);
        restoDesl   = {resto, quociente[LARGURA-1]};
        if (restoDesl >= {1'b0, bReg}) begin
            restoProx = LARGURA'(restoDesl - {1'b0, bReg});
            quocProx  = {quociente[LARGURA-2:0], 1'b1};
        end else begin
            restoProx = restoDesl[LARGURA-1:0];
            quocProx  = {quociente[LARGURA-2:0], 1'b0};
        end

        resultadoSimples = operaSimples(Op, Dado1, Dado2);
        aceita           = (estado == OCIOSO) && Inicio;
        entraEscrita     = (aceita && !ehMulticiclo(Op)) ||
                           ((estado == CALC) && (contador == ULTIMA));

        if (estado != CALC)
            resultadoProx = resultadoSimples;
        else if (opReg == OP_MUL)
            resultadoProx = produtoProx[LARGURA-1:0];
        else if (opReg == OP_DIV)
            resultadoProx = quocProx;
        else
            resultadoProx = restoProx;
    end

    assign Ocupado = (estado != OCIOSO);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            RegWrite <= 1'b0;
            Pronto   <= 1'b0;
            DadoEscr <= '0;
            RegEscr  <= '0;
        end else begin
            RegWrite <= entraEscrita;
            Pronto   <= entraEscrita;
            if (entraEscrita)
                DadoEscr <= resultadoProx;
            case (estado)
                OCIOSO: begin
                    if (Inicio) begin
                        RegEscr  <= RegDestino;
                        contador <= '0;
                        estado   <= ehMulticiclo(Op) ? CALC : ESCRITA;
                    end
                end
                CALC: begin
                    contador <= contador + 1'b1;
                    if (contador == ULTIMA)
                        estado <= ESCRITA;
                end
                ESCRITA: estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Datapath registers carry no reset: they are always reloaded when an operation is accepted.
    always_ff @(posedge Clock) begin
        if (aceita) begin
            opReg     <= Op;
            aReg      <= Dado1;
            bReg      <= Dado2;
            produto   <= '0;
            resto     <= '0;
            quociente <= Dado1;
        end else if (estado == CALC) begin
            produto   <= produtoProx;
            resto     <= restoProx;
            quociente <= quocProx;
        end
    end

`ifdef ULA_FLAGS_EN
    logic overflowProx;

    always_comb begin
        overflowProx = 1'b0;
        if (estado == CALC) begin
            if (opReg == OP_MUL)
                overflowProx = |produtoProx[2*LARGURA-1:LARGURA];
            else
                overflowProx = (bReg == '0);
        end else if (Op == OP_ADD) begin
            overflowProx = (Dado1[LARGURA-1] == Dado2[LARGURA-1]) &&
                           (resultadoSimples[LARGURA-1] != Dado1[LARGURA-1]);
        end else if (Op == OP_SUB) begin
            overflowProx = (Dado1[LARGURA-1] != Dado2[LARGURA-1]) &&
                           (resultadoSimples[LARGURA-1] != Dado1[LARGURA-1]);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Zero     <= 1'b0;
            Overflow <= 1'b0;
        end else if (entraEscrita) begin
            Zero     <= (resultadoProx == '0);
            Overflow <= overflowProx;
        end
    end
`else
    assign Zero     = 1'b0;
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed-vector bench for ula_multiciclo with a small register-file model on the write port.
module tb_ula_multiciclo;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] MUL = 3'b100;
    localparam logic [2:0] DIV = 3'b101;
    localparam logic [2:0] MOD = 3'b110;
    localparam logic [2:0] SLT = 3'b111;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Inicio;
    logic [2:0] Op;
    logic [7:0] Dado1;
    logic [7:0] Dado2;
    logic [2:0] RegDestino;
    logic       Ocupado;
    logic       Pronto;
    logic [7:0] DadoEscr;
    logic [2:0] RegEscr;
    logic       RegWrite;
    logic       Zero;
    logic       Overflow;

    int nAsserts = 0;
    int nFalhas  = 0;

    logic [7:0] bancoRegs [8];

    always #5 Clock = ~Clock;

    ula_multiciclo #(.LARGURA(8), .NUM_REG_BITS(3)) dut (
        .Clock(Clock), .Reset(Reset), .Inicio(Inicio), .Op(Op),
        .Dado1(Dado1), .Dado2(Dado2), .RegDestino(RegDestino),
        .Ocupado(Ocupado), .Pronto(Pronto), .DadoEscr(DadoEscr),
        .RegEscr(RegEscr), .RegWrite(RegWrite), .Zero(Zero), .Overflow(Overflow)
    );

    always @(posedge Clock) begin
        if (RegWrite === 1'b1)
            bancoRegs[RegEscr] <= DadoEscr;
    end

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        nAsserts++;
        if (obs !== esp) begin
            nFalhas++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
        end
    endtask

    task automatic confereFlags(input string tag, input logic zEsp, input logic vEsp);
`ifdef ULA_FLAGS_EN
        confere({tag, ":zero"}, Zero, zEsp);
        confere({tag, ":ovf"}, Overflow, vEsp);
`else
        confere({tag, ":zero"}, Zero, 1'b0);
        confere({tag, ":ovf"}, Overflow, 1'b0);
`endif
    endtask

    // Start one operation, scramble operands afterwards, optionally pulse Inicio while busy.
    task automatic executa(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] rd, input logic [7:0] esp,
                           input int latEsp, input logic zEsp, input logic vEsp,
                           input logic ruido);
        int n;
        int nOcup;
        n = 0;
        nOcup = 0;
        @(negedge Clock);
        Op = op; Dado1 = a; Dado2 = b; RegDestino = rd; Inicio = 1'b1;
        do begin
            @(negedge Clock);
            n++;
            if (Ocupado === 1'b1) nOcup++;
            Inicio = (ruido && RegWrite !== 1'b1) ? n[0] : 1'b0;
            Dado1 = 8'($urandom);
            Dado2 = 8'($urandom);
            RegDestino = ~rd;
        end while (RegWrite !== 1'b1 && n < 20);
        Inicio = 1'b0;
        confere({tag, ":latency"}, n, latEsp);
        confere({tag, ":busy"}, nOcup, latEsp);
        confere({tag, ":data"}, DadoEscr, esp);
        confere({tag, ":reg"}, RegEscr, rd);
        confere({tag, ":pronto"}, Pronto, 1'b1);
        confereFlags(tag, zEsp, vEsp);
        @(negedge Clock);
        confere({tag, ":rw_drop"}, RegWrite, 1'b0);
        confere({tag, ":pronto_drop"}, Pronto, 1'b0);
        confere({tag, ":idle"}, Ocupado, 1'b0);
        confere({tag, ":hold"}, DadoEscr, esp);
        confere({tag, ":regfile"}, bancoRegs[rd], esp);
    endtask

    initial begin
        int pulsos;
        Reset = 1'b0; Inicio = 1'b1; Op = ADD; Dado1 = 8'h03; Dado2 = 8'h04; RegDestino = 3'd1;
        @(negedge Clock);
        @(negedge Clock);
        confere("rst:ocupado", Ocupado, 1'b0);
        confere("rst:pronto", Pronto, 1'b0);
        confere("rst:dado", DadoEscr, 8'h00);
        confere("rst:reg", RegEscr, 3'd0);
        confere("rst:rw", RegWrite, 1'b0);
        confere("rst:zero", Zero, 1'b0);
        confere("rst:ovf", Overflow, 1'b0);
        Reset = 1'b1; Inicio = 1'b0;

        executa("add",     ADD, 8'h03, 8'h04, 3'd1, 8'h07, 1, 1'b0, 1'b0, 1'b0);
        executa("add_ovf", ADD, 8'h7F, 8'h01, 3'd2, 8'h80, 1, 1'b0, 1'b1, 1'b0);
        executa("sub_zero", SUB, 8'h05, 8'h05, 3'd3, 8'h00, 1, 1'b1, 1'b0, 1'b0);
        executa("sub_ovf", SUB, 8'h80, 8'h01, 3'd4, 8'h7F, 1, 1'b0, 1'b1, 1'b0);
        executa("slt_neg", SLT, 8'h80, 8'h01, 3'd6, 8'h01, 1, 1'b0, 1'b0, 1'b0);
        executa("slt_no",  SLT, 8'h05, 8'hFF, 3'd7, 8'h00, 1, 1'b1, 1'b0, 1'b0);
        executa("mul",     MUL, 8'h10, 8'h11, 3'd5, 8'h10, 9, 1'b0, 1'b1, 1'b1);
        executa("mul_ff",  MUL, 8'hFF, 8'hFF, 3'd1, 8'h01, 9, 1'b0, 1'b1, 1'b0);
        executa("mul_sm",  MUL, 8'h0C, 8'h0D, 3'd2, 8'h9C, 9, 1'b0, 1'b0, 1'b0);
        executa("div",     DIV, 8'd200, 8'd7, 3'd3, 8'd28, 9, 1'b0, 1'b0, 1'b1);
        executa("mod",     MOD, 8'd200, 8'd7, 3'd4, 8'd4, 9, 1'b0, 1'b0, 1'b0);
        executa("div0",    DIV, 8'd9, 8'd0, 3'd5, 8'hFF, 9, 1'b0, 1'b1, 1'b0);
        executa("mod0",    MOD, 8'd9, 8'd0, 3'd6, 8'd9, 9, 1'b0, 1'b1, 1'b0);
        executa("mod_z",   MOD, 8'd21, 8'd7, 3'd7, 8'd0, 9, 1'b1, 1'b0, 1'b0);

        // Reset lands on the 4th CALC edge of a MUL.
        @(negedge Clock);
        Op = MUL; Dado1 = 8'h10; Dado2 = 8'h11; RegDestino = 3'd6; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        repeat (2) @(negedge Clock);
        confere("abort:busy_before", Ocupado, 1'b1);
        Reset = 1'b0;
        @(negedge Clock);
        confere("abort:ocupado", Ocupado, 1'b0);
        confere("abort:rw", RegWrite, 1'b0);
        confere("abort:dado", DadoEscr, 8'h00);
        Reset = 1'b1;
        pulsos = 0;
        repeat (12) begin
            @(negedge Clock);
            if (RegWrite === 1'b1) pulsos++;
        end
        confere("abort:no_write", pulsos, 0);
        executa("add_after", ADD, 8'h20, 8'h22, 3'd6, 8'h42, 1, 1'b0, 1'b0, 1'b0);

        // Inicio held high across two simple ops.
        @(negedge Clock);
        Op = AND; Dado1 = 8'hF0; Dado2 = 8'h3C; RegDestino = 3'd1; Inicio = 1'b1;
        @(negedge Clock);
        confere("b2b:rw1", RegWrite, 1'b1);
        confere("b2b:dado1", DadoEscr, 8'h30);
        confere("b2b:reg1", RegEscr, 3'd1);
        Op = OR; RegDestino = 3'd2;
        @(negedge Clock);
        confere("b2b:gap_rw", RegWrite, 1'b0);
        confere("b2b:gap_idle", Ocupado, 1'b0);
        @(negedge Clock);
        confere("b2b:rw2", RegWrite, 1'b1);
        confere("b2b:dado2", DadoEscr, 8'hFC);
        confere("b2b:reg2", RegEscr, 3'd2);
        Inicio = 1'b0;
        @(negedge Clock);
        confere("b2b:rw_drop", RegWrite, 1'b0);
        confere("b2b:rf1", bancoRegs[1], 8'h30);
        confere("b2b:rf2", bancoRegs[2], 8'hFC);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFalhas);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Multi-cycle 8-bit ALU stage directly downstream of the register file (BancoDeRegistradores).
- Consumes the two read operands Dado1/Dado2 and produces the write-back triple DadoEscr/RegEscr/RegWrite that drives the register file's write port.
- Single-cycle logic ops plus iterative MUL/DIV/MOD, with a Inicio/Ocupado/Pronto handshake to the control unit.

Parameters:
- LARGURA, 8, operand/result width in bits.
- NUM_REG_BITS, 3, width of register-index fields.

Ports:
- Clock  input  1  system clock; all state on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Inicio  input  1  start request; sampled only in state OCIOSO.
- Op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 MOD, 111 SLT (signed).
- Dado1  input  LARGURA  operand A from register file.
- Dado2  input  LARGURA  operand B from register file.
- RegDestino  input  NUM_REG_BITS  destination register index.
- Ocupado  output  1  high whenever state != OCIOSO.
- Pronto  output  1  one-cycle pulse, coincident with RegWrite.
- DadoEscr  output  LARGURA  result to register-file write data.
- RegEscr  output  NUM_REG_BITS  latched RegDestino to register-file write index.
- RegWrite  output  1  write enable, high exactly one cycle per operation.
- Zero  output  1  result == 0 (see Optional Feature).
- Overflow  output  1  overflow / divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset is synchronous, active-low, and has priority over everything.
  - Reset low at an edge forces state OCIOSO, iteration counter 0.
  - All outputs read 0 after that edge: Ocupado, Pronto, DadoEscr, RegEscr, RegWrite, Zero, Overflow.
  - Reset mid-operation aborts the operation; no RegWrite is issued.
- All outputs are registered; no combinational path from inputs to outputs.
- State OCIOSO:
  - If Inicio=1 at edge k, latch Op, Dado1, Dado2, RegDestino.
  - Op 000–011 or 111: compute result, go to ESCRITA.
  - Op 100–110: go to CALC with counter 0.
- State CALC:
  - One iteration per edge; after the 8th iteration (counter==7) go to ESCRITA.
  - MUL: shift-add, 16-bit product; DadoEscr = low byte.
  - DIV/MOD: restoring division; DIV returns the quotient, MOD returns the remainder.
- State ESCRITA:
  - RegWrite=1, Pronto=1, DadoEscr and RegEscr valid for exactly one cycle.
  - Next edge: return to OCIOSO and drop RegWrite and Pronto.
- Latency, counting Inicio sampled at edge k:
  - Simple ops: RegWrite high after edge k; register file captures at edge k+1.
  - MUL/DIV/MOD: RegWrite high after edge k+8; captured at edge k+9.
- Back-to-back: Inicio may be high in the cycle after ESCRITA (state OCIOSO) and is accepted there. Inicio is ignored while Ocupado=1.
- DadoEscr and RegEscr hold their last values after ESCRITA until the next result is loaded.
- Arithmetic rules:
  - ADD/SUB wrap modulo 256.
  - SLT result is 8'h01 if signed A < signed B, else 8'h00.
- Divide by zero (Dado2=0): no special path. The restoring algorithm yields DIV=8'hFF and MOD=dividend; latency is unchanged.
- Operands change after latching: Dado1/Dado2 may change freely after edge k without affecting the result.

Optional Feature:
- Macro ULA_FLAGS_EN.
- Defined: Zero and Overflow are registered at ESCRITA entry and held until the next ESCRITA entry.
  - Zero = (result == 0).
  - Overflow = signed overflow for ADD/SUB; product[15:8] != 0 for MUL; Dado2 == 0 for DIV/MOD; 0 for AND/OR/SLT.
- Undefined: Zero and Overflow are tied to 0 and the flag logic is not synthesised.

Test Plan:
- Reset: hold Reset=0 two edges with Inicio=1 → all outputs 0, Ocupado=0. Release, then ADD 8'h03+8'h04 → DadoEscr=8'h07, RegWrite exactly one cycle, captured one edge after Inicio's edge +1.
- ADD overflow: 8'h7F + 8'h01 → DadoEscr=8'h80. With ULA_FLAGS_EN: Overflow=1, Zero=0. SUB 8'h05-8'h05 → 8'h00, Zero=1.
- MUL: 8'h10 × 8'h11, RegDestino=3'd5 → Ocupado high 9 cycles, DadoEscr=8'h10, RegEscr=3'd5. Flags build: Overflow=1. Inicio pulses during CALC are ignored.
- DIV/MOD: 8'd200 ÷ 8'd7 → DIV=8'd28, MOD=8'd4. Divisor 0 with dividend 8'd9 → DIV=8'hFF, MOD=8'd9; flags build: Overflow=1.
- Reset mid-MUL: assert Reset=0 at the 4th CALC edge → next cycle Ocupado=0 and no RegWrite pulse. Following ADD completes normally.
- Back-to-back with register file: Inicio held high across two ops (AND 8'hF0&8'h3C, then OR same) → two RegWrite pulses separated by one OCIOSO cycle. Register file reads back 8'h30 and 8'hFC.
